divider_controller: RTL and testbench

DIVIDER_CONTROLLER -- requirements
Module: divider_controller

---
 rtl/divider_pkg.sv | 72 +++++++
 rtl/start_edge_det.sv | 21 ++
 rtl/divider_controller.sv | 128 ++++++++++++
 tb/tb_divider_controller.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared definitions for the divider: controller state encoding, counter
// constants and the per-state strobe decode.
package divider_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    CLEAR  = 4'd1,
    LOAD   = 4'd2,
    CHECK  = 4'd3,
    INIT   = 4'd4,
    CALC   = 4'd5,
    UPDATE = 4'd6,
    DONE   = 4'd7,
    ERR    = 4'd8
  } state_t;

  // The datapath counter is preset to CNT_PRESET and raises its carry-out at
  // CNT_LAST, which leaves CNT_LAST - CNT_PRESET + 1 = 14 iterations.
  localparam logic [3:0] CNT_PRESET = 4'd2;
  localparam logic [3:0] CNT_LAST   = 4'd15;

  typedef struct packed {
    logic sclr;
    logic ld_a;
    logic ld_b;
    logic ld_acc;
    logic ld_acc_next;
    logic ld_q;
    logic ld_q_next;
    logic cnt_en;
    logic init_cnt;
    logic mux_init;
    logic mux_data;
    logic busy;
    logic done;
  } ctrl_t;

  // Strobes are a pure function of the state, so registering decode(next
  // state) yields outputs that line up with the state register.
  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c      = '0;
    c.busy = (s != IDLE);
    case (s)
      CLEAR:  c.sclr = 1'b1;
      LOAD: begin
        c.ld_a = 1'b1;
        c.ld_b = 1'b1;
      end
      INIT: begin
        c.mux_init = 1'b1;
        c.ld_acc   = 1'b1;
        c.ld_q     = 1'b1;
        c.init_cnt = 1'b1;
      end
      CALC: begin
        c.ld_acc_next = 1'b1;
        c.ld_q_next   = 1'b1;
      end
      UPDATE: begin
        c.mux_data = 1'b1;
        c.ld_acc   = 1'b1;
        c.ld_q     = 1'b1;
        c.cnt_en   = 1'b1;
      end
      DONE:   c.done = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/start_edge_det.sv
// Rising-edge detector for the start request; the history bit resets high so
// a level already present when reset is released is not seen as an edge.
module start_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic pulse
);

  logic prev;

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge value of its inputs regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b1;
    else        prev <= in;
  end

  assign pulse = in & ~prev;

endmodule

// File: rtl/divider_controller.sv
// Sequencing FSM for the iterative divider datapath: clear, load, zero-check,
// init, 14 CALC/UPDATE iterations, then DONE or ERR, with sticky error flags.
module divider_controller
  import divider_pkg::*;
#(
  parameter bit START_EDGE = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic dvz,
  input  logic ovf,
  input  logic cnt_co,
  output logic sclr,
  output logic ld_A,
  output logic ld_B,
  output logic ld_ACC,
  output logic ld_ACCnext,
  output logic ld_Q,
  output logic ld_Qnext,
  output logic cnt_en,
  output logic init_cnt,
  output logic mux_init,
  output logic mux_data,
  output logic busy,
  output logic done,
  output logic err_dvz,
  output logic err_ovf
);

  state_t state, state_nxt;
  ctrl_t  ctrl;
  logic   err_dvz_q, err_ovf_q;
  logic   err_dvz_nxt, err_ovf_nxt;
  logic   start_pulse;
  logic   accept;

  start_edge_det u_start_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (start),
    .pulse (start_pulse)
  );

  assign accept = START_EDGE ? start_pulse : start;

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt   = state;
    err_dvz_nxt = err_dvz_q;
    err_ovf_nxt = err_ovf_q;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt   = CLEAR;
          err_dvz_nxt = 1'b0;
          err_ovf_nxt = 1'b0;
        end
      end
      CLEAR:  state_nxt = LOAD;
      LOAD:   state_nxt = CHECK;
      CHECK: begin
        if (dvz) begin
          err_dvz_nxt = 1'b1;
          state_nxt   = ERR;
        end else begin
          state_nxt   = INIT;
        end
      end
      INIT:   state_nxt = CALC;
      CALC:   state_nxt = UPDATE;
      UPDATE: begin
        if (ovf) begin
          err_ovf_nxt = 1'b1;
          state_nxt   = ERR;
        end else if (cnt_co) begin
          state_nxt   = DONE;
        end else begin
          state_nxt   = CALC;
        end
      end
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state, so they change only on a
  // clock edge and never follow an input combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ctrl      <= '0;
      err_dvz_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      ctrl      <= decode(state_nxt);
      err_dvz_q <= err_dvz_nxt;
      err_ovf_q <= err_ovf_nxt;
    end
  end

  assign sclr       = ctrl.sclr;
  assign ld_A       = ctrl.ld_a;
  assign ld_B       = ctrl.ld_b;
  assign ld_ACC     = ctrl.ld_acc;
  assign ld_ACCnext = ctrl.ld_acc_next;
  assign ld_Q       = ctrl.ld_q;
  assign ld_Qnext   = ctrl.ld_q_next;
  assign cnt_en     = ctrl.cnt_en;
  assign init_cnt   = ctrl.init_cnt;
  assign mux_init   = ctrl.mux_init;
  assign mux_data   = ctrl.mux_data;
  assign busy       = ctrl.busy;
  assign done       = ctrl.done;
  assign err_dvz    = err_dvz_q;
  assign err_ovf    = err_ovf_q;

  // Datapath input selects and the clear must never overlap.
  a_sel_excl: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({sclr, ld_A | ld_B, mux_init, mux_data}));

  a_done_idle_next: assert property (@(posedge clk) disable iff (!rst_n)
    done |=> !busy);

endmodule

// File: tb/tb_divider_controller.sv
// Directed bench for divider_controller with a small counter model standing
// in for the datapath; a second instance exercises level-sensitive start.
module tb_divider_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       dvz;
  logic       ovf;
  logic       cnt_co;
  logic       ovf_mode;
  logic [3:0] cnt;

  logic sclr, ld_A, ld_B, ld_ACC, ld_ACCnext, ld_Q, ld_Qnext;
  logic cnt_en, init_cnt, mux_init, mux_data, busy, done, err_dvz, err_ovf;

  logic        start_l;
  logic [14:0] lvl_o;

  int total = 0;
  int bad   = 0;

  int n_done, first_done, busy_cnt, calc_cnt, excl_bad, sclr_cnt, late_strobes;
  bit busy_log [0:79];
  bit done_log [0:79];
  bit errd_log [0:79];
  bit erro_log [0:79];
  bit strb_log [0:79];
  bit sclr_log [0:79];
  bit lda_log  [0:79];
  bit init_log [0:79];

  always #5 clk = ~clk;

  divider_controller #(.START_EDGE(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dvz        (dvz),
    .ovf        (ovf),
    .cnt_co     (cnt_co),
    .sclr       (sclr),
    .ld_A       (ld_A),
    .ld_B       (ld_B),
    .ld_ACC     (ld_ACC),
    .ld_ACCnext (ld_ACCnext),
    .ld_Q       (ld_Q),
    .ld_Qnext   (ld_Qnext),
    .cnt_en     (cnt_en),
    .init_cnt   (init_cnt),
    .mux_init   (mux_init),
    .mux_data   (mux_data),
    .busy       (busy),
    .done       (done),
    .err_dvz    (err_dvz),
    .err_ovf    (err_ovf)
  );

  // Level-sensitive instance with divisor permanently zero.
  divider_controller #(.START_EDGE(1'b0)) dut_lvl (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start_l),
    .dvz        (1'b1),
    .ovf        (1'b0),
    .cnt_co     (1'b0),
    .sclr       (lvl_o[14]),
    .ld_A       (lvl_o[13]),
    .ld_B       (lvl_o[12]),
    .ld_ACC     (lvl_o[11]),
    .ld_ACCnext (lvl_o[10]),
    .ld_Q       (lvl_o[9]),
    .ld_Qnext   (lvl_o[8]),
    .cnt_en     (lvl_o[7]),
    .init_cnt   (lvl_o[6]),
    .mux_init   (lvl_o[5]),
    .mux_data   (lvl_o[4]),
    .busy       (lvl_o[3]),
    .done       (lvl_o[2]),
    .err_dvz    (lvl_o[1]),
    .err_ovf    (lvl_o[0])
  );

  // Datapath iteration counter: clear, preset to 2, increment.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)        cnt <= 4'd0;
    else if (sclr)     cnt <= 4'd0;
    else if (init_cnt) cnt <= 4'd2;
    else if (cnt_en)   cnt <= cnt + 4'd1;
  end

  assign cnt_co = (cnt == 4'd15);
  assign ovf    = ovf_mode & (cnt == 4'd11);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] all_outs();
    return {sclr, ld_A, ld_B, ld_ACC, ld_ACCnext, ld_Q, ld_Qnext, cnt_en,
            init_cnt, mux_init, mux_data, busy, done, err_dvz, err_ovf};
  endfunction

  // Start is raised in cycle 0; cycle k is observed at the k-th falling edge
  // after that. start drops at cycle 'hold'; an optional extra pulse at
  // cycle 'extra_at'.
  task automatic run_div(input int ncyc, input int hold, input int extra_at);
    logic any;
    @(negedge clk);
    start        = 1'b1;
    n_done       = 0;
    first_done   = -1;
    busy_cnt     = 0;
    calc_cnt     = 0;
    excl_bad     = 0;
    sclr_cnt     = 0;
    late_strobes = 0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (k == hold) start = 1'b0;
      if (extra_at != 0 && k == extra_at) start = 1'b1;
      if (extra_at != 0 && k == extra_at + 1) start = 1'b0;
      any = sclr | ld_A | ld_B | ld_ACC | ld_ACCnext | ld_Q | ld_Qnext |
            cnt_en | init_cnt | mux_init | mux_data;
      busy_log[k] = busy;
      done_log[k] = done;
      errd_log[k] = err_dvz;
      erro_log[k] = err_ovf;
      strb_log[k] = any;
      sclr_log[k] = sclr;
      lda_log[k]  = ld_A & ld_B;
      init_log[k] = mux_init;
      if (done) begin
        n_done++;
        if (first_done < 0) first_done = k;
      end
      if (busy)       busy_cnt++;
      if (ld_ACCnext) calc_cnt++;
      if (sclr)       sclr_cnt++;
      if (int'(sclr) + int'(ld_A | ld_B) + int'(mux_init) + int'(mux_data) > 1) excl_bad++;
      if (first_done > 0 && k > first_done && any) late_strobes++;
    end
  endtask

  initial begin
    int main_busy;
    bit lvl_busy [0:7];
    bit lvl_errd [0:7];

    rst_n    = 1'b0;
    start    = 1'b1;
    start_l  = 1'b1;
    dvz      = 1'b0;
    ovf_mode = 1'b0;

    // Reset state, with start already high on both instances.
    repeat (2) @(negedge clk);
    check("reset_outs", 32'(all_outs()), 32'd0);
    check("reset_outs_lvl", 32'(lvl_o), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    main_busy = 0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (busy) main_busy++;
      lvl_busy[k] = lvl_o[3];
      lvl_errd[k] = lvl_o[1];
    end
    check("edge_start_high_at_release", 32'(main_busy), 32'd0);
    check("lvl_accept_cycle1", 32'(lvl_busy[1]), 32'd1);
    check("lvl_dvz_err_cycle4", 32'(lvl_errd[4]), 32'd1);
    check("lvl_idle_cycle5", 32'(lvl_busy[5]), 32'd0);
    check("lvl_retrigger_cycle6", 32'(lvl_busy[6]), 32'd1);
    check("lvl_err_cleared_cycle6", 32'(lvl_errd[6]), 32'd0);
    start   = 1'b0;
    start_l = 1'b0;
    repeat (6) @(negedge clk);

    // Normal division (A=100, B=7).
    run_div(40, 1, 0);
    check("norm_sclr_cycle1", 32'(sclr_log[1]), 32'd1);
    check("norm_sclr_once", 32'(sclr_cnt), 32'd1);
    check("norm_load_cycle2", 32'(lda_log[2]), 32'd1);
    check("norm_init_cycle4", 32'(init_log[4]), 32'd1);
    check("norm_calc_count", 32'(calc_cnt), 32'd14);
    check("norm_done_cycle", 32'(first_done), 32'd33);
    check("norm_done_count", 32'(n_done), 32'd1);
    check("norm_busy_cycles", 32'(busy_cnt), 32'd33);
    check("norm_idle_cycle34", 32'(busy_log[34]), 32'd0);
    check("norm_no_strobe_after_done", 32'(late_strobes), 32'd0);
    check("norm_sel_exclusive", 32'(excl_bad), 32'd0);
    check("norm_err_flags", 32'({err_dvz, err_ovf}), 32'd0);

    // Divide by zero.
    dvz = 1'b1;
    run_div(10, 1, 0);
    check("dvz_err_not_yet_c3", 32'(errd_log[3]), 32'd0);
    check("dvz_err_c4", 32'(errd_log[4]), 32'd1);
    check("dvz_err_state_busy_c4", 32'(busy_log[4]), 32'd1);
    check("dvz_err_state_strobes_c4", 32'(strb_log[4]), 32'd0);
    check("dvz_idle_c5", 32'(busy_log[5]), 32'd0);
    check("dvz_no_calc", 32'(calc_cnt), 32'd0);
    check("dvz_no_done", 32'(n_done), 32'd0);
    check("dvz_sticky", 32'(errd_log[10]), 32'd1);
    check("dvz_no_ovf", 32'(erro_log[10]), 32'd0);
    dvz = 1'b0;

    // Overflow at count 11 (UPDATE in cycle 24).
    ovf_mode = 1'b1;
    run_div(30, 1, 0);
    check("ovf_dvz_cleared_c1", 32'(errd_log[1]), 32'd0);
    check("ovf_not_yet_c24", 32'(erro_log[24]), 32'd0);
    check("ovf_err_c25", 32'(erro_log[25]), 32'd1);
    check("ovf_err_state_busy_c25", 32'(busy_log[25]), 32'd1);
    check("ovf_err_state_strobes_c25", 32'(strb_log[25]), 32'd0);
    check("ovf_idle_c26", 32'(busy_log[26]), 32'd0);
    check("ovf_no_done", 32'(n_done), 32'd0);
    check("ovf_sticky", 32'(erro_log[30]), 32'd1);
    ovf_mode = 1'b0;

    // Extra start pulse while busy.
    run_div(40, 1, 10);
    check("extra_ovf_cleared_c1", 32'(erro_log[1]), 32'd0);
    check("extra_done_cycle", 32'(first_done), 32'd33);
    check("extra_done_count", 32'(n_done), 32'd1);
    check("extra_busy_cycles", 32'(busy_cnt), 32'd33);

    // Asynchronous reset in cycle 15 of a division.
    run_div(14, 1, 0);
    @(negedge clk);
    check("rst_busy_before", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 check("rst_outs_immediate", 32'(all_outs()), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_div(40, 1, 0);
    check("rst_fresh_done_cycle", 32'(first_done), 32'd33);
    check("rst_fresh_done_count", 32'(n_done), 32'd1);

    // Start held high for 50 cycles.
    run_div(60, 50, 0);
    check("hold_done_cycle", 32'(first_done), 32'd33);
    check("hold_done_count", 32'(n_done), 32'd1);
    check("hold_busy_cycles", 32'(busy_cnt), 32'd33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
